// File: rtl/piece_drop_animator.sv
// Animates a Connect-4 token falling down one column, one row per slow-clock rising edge.
// The slow clock is synchronized into clk_in and edge-detected into a single-cycle step.
//
// state | meaning
// IDLE  | waiting for start; start requests are accepted or rejected here
// FALL  | token descending; one row check per step
module piece_drop_animator #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            slow_clk,
  input  logic            start,
  input  logic [2:0]      col,
  input  logic            player,
  input  logic [ROWS-1:0] col_occ,
  output logic            busy,
  output logic [2:0]      anim_row,
  output logic [2:0]      anim_col,
  output logic            anim_player,
  output logic            done,
  output logic [2:0]      land_row,
  output logic            reject
);

  localparam logic [2:0] ROW_LAST  = 3'(ROWS - 1);
  localparam logic [3:0] COL_LIMIT = 4'(COLS);

  typedef enum logic {IDLE, FALL} state_t;

  state_t     state;
  logic       s1, s2, s3;
  logic       step;
  logic       blocked;
  logic [2:0] next_row;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step     = s2 & ~s3;
  assign next_row = anim_row + 3'd1;

  // The bottom row is always a landing spot; the row index past it is never read.
  always_comb begin
    blocked = 1'b1;
    if (anim_row < ROW_LAST) blocked = col_occ[next_row];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      anim_row    <= 3'd0;
      anim_col    <= 3'd0;
      anim_player <= 1'b0;
      done        <= 1'b0;
      land_row    <= 3'd0;
      reject      <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (({1'b0, col} >= COL_LIMIT) || col_occ[0]) begin
              reject <= 1'b1;
            end else begin
              anim_col    <= col;
              anim_player <= player;
              anim_row    <= 3'd0;
              busy        <= 1'b1;
              state       <= FALL;
            end
          end
        end
        FALL: begin
          if (step) begin
            if (blocked) begin
              done     <= 1'b1;
              land_row <= anim_row;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              anim_row <= next_row;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_drop_animator.sv
// Bench for piece_drop_animator: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a landing-row/step-count model of the board.
module tb_piece_drop_animator;

  logic       clk_in, rst_n, slow_clk, start, player;
  logic [2:0] col;
  logic [5:0] col_occ;
  logic       busy, anim_player, done, reject;
  logic [2:0] anim_row, anim_col, land_row;

  logic [5:0] board [8];
  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic       m_busy, m_done, m_reject, m_player, m_step;
  logic [2:0] m_row, m_col, m_land;
  int         m_target, m_steps;
  logic       h1, h2, h3;

  // slow clock generator controls
  logic slow_auto, slow_force;
  int   slow_per, slow_cnt;
  int   k_fill;

  piece_drop_animator #(.ROWS(6), .COLS(7)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .start(start), .col(col),
    .player(player), .col_occ(col_occ), .busy(busy), .anim_row(anim_row),
    .anim_col(anim_col), .anim_player(anim_player), .done(done), .land_row(land_row),
    .reject(reject)
  );

  // upstream board logic: occupancy of the animating column while busy, else of col
  assign col_occ = busy ? board[anim_col] : board[col];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    slow_clk = 1'b0;
    slow_cnt = 0;
  end

  always @(negedge clk_in) begin
    if (!slow_auto) slow_clk = slow_force;
    else if (slow_cnt <= 0) begin
      slow_clk = ~slow_clk;
      slow_cnt = slow_per;
    end else slow_cnt--;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Token lands just above the first filled row from the top, else on the bottom row.
  function automatic int land_of(input logic [5:0] occ);
    for (int r = 1; r < 6; r++) if (occ[r]) return r - 1;
    return 5;
  endfunction

  // A slow_clk rise first seen at edge n acts at edge n+2; landing at row r takes r+1 steps.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_reject = 0; m_player = 0;
      m_row = 0; m_col = 0; m_land = 0; m_target = 0; m_steps = 0;
      h1 = 0; h2 = 0; h3 = 0; m_step = 0;
    end else begin
      m_step = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = slow_clk;
      m_done = 0;
      m_reject = 0;
      if (!m_busy) begin
        if (start) begin
          if (col >= 3'd7 || board[col][0]) m_reject = 1;
          else begin
            m_busy = 1; m_col = col; m_player = player;
            m_row = 0; m_steps = 0; m_target = land_of(board[col]);
          end
        end
      end else if (m_step) begin
        if (m_steps == m_target) begin
          m_done = 1;
          m_land = 3'(m_target);
          m_busy = 0;
          board[m_col][m_land] = 1'b1;
        end else begin
          m_steps++;
          m_row = 3'(m_steps);
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("anim_row", anim_row, m_row);
      chk("anim_col", anim_col, m_col);
      chk("anim_player", anim_player, m_player);
      chk("done", done, m_done);
      chk("land_row", land_row, m_land);
      chk("reject", reject, m_reject);
    end
  end

  task automatic pulse(input logic [2:0] c, input logic p);
    start = 1'b1; col = c; player = p;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic got, output logic [2:0] lr,
                           output logic [7:0] mask);
    got = 0; lr = 0; mask = 0;
    for (int k = 0; k < budget; k++) begin
      if (busy) mask |= 8'(1 << anim_row);
      if (done) begin
        got = 1;
        lr = land_row;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  logic       got;
  logic [2:0] lr;
  logic [7:0] mask;
  logic       seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; col = 3'd0; player = 1'b0;
    slow_auto = 1'b1; slow_force = 1'b0; slow_per = 3;
    for (int c = 0; c < 8; c++) board[c] = 6'd0;
    repeat (3) @(negedge clk_in);
    chk("reset_outputs", {busy, anim_row, anim_col, anim_player, done, land_row, reject}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);

    // empty column drops to the bottom
    pulse(3'd3, 1'b1);
    chk("t1_busy", busy, 1);
    wait_done(600, got, lr, mask);
    chk("t1_done", got, 1);
    chk("t1_land", lr, 5);
    chk("t1_rows", mask, 8'h3f);
    chk("t1_busy_fall", busy, 0);
    chk("t1_commit", {anim_col, anim_player}, {3'd3, 1'b1});

    // rows 3..5 full, then a second drop started in the done cycle
    board[2] = 6'b111000;
    repeat (2) @(negedge clk_in);
    pulse(3'd2, 1'b0);
    wait_done(600, got, lr, mask);
    chk("t2_done", got, 1);
    chk("t2_land", lr, 2);
    chk("t2_rows", mask, 8'h07);
    pulse(3'd2, 1'b1);
    chk("t2b_accept", busy, 1);
    wait_done(600, got, lr, mask);
    chk("t2b_land", lr, 1);

    // rejects: full column, out-of-range column
    board[4] = 6'b111111;
    @(negedge clk_in);
    pulse(3'd4, 1'b0);
    chk("t3_reject", {reject, busy, anim_col}, {1'b1, 1'b0, 3'd2});
    @(negedge clk_in);
    chk("t3_reject_one_cycle", reject, 0);
    pulse(3'd7, 1'b0);
    chk("t3_reject_col7", {reject, busy, anim_col}, {1'b1, 1'b0, 3'd2});

    // start while busy is ignored
    board[5] = 6'd0;
    @(negedge clk_in);
    pulse(3'd5, 1'b0);
    @(negedge clk_in);
    pulse(3'd1, 1'b1);
    chk("t4_ignored", {reject, busy, anim_col, anim_player}, {1'b0, 1'b1, 3'd5, 1'b0});
    wait_done(600, got, lr, mask);
    chk("t4_land", lr, 5);

    // reset mid-fall
    board[6] = 6'd0;
    @(negedge clk_in);
    pulse(3'd6, 1'b1);
    for (int k = 0; k < 400 && anim_row != 3'd2; k++) @(negedge clk_in);
    chk("t5_reach_row2", anim_row, 2);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", {busy, anim_row, anim_col, anim_player, done, land_row, reject}, 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (done) seen = 1;
    end
    chk("t5_no_done", seen, 0);
    pulse(3'd6, 1'b0);
    wait_done(600, got, lr, mask);
    chk("t5_restart_land", {got, lr}, {1'b1, 3'd5});

    // slow_clk held high yields one step only
    slow_auto = 1'b0; slow_force = 1'b0;
    board[0] = 6'd0;
    repeat (6) @(negedge clk_in);
    pulse(3'd0, 1'b0);
    slow_force = 1'b1;
    repeat (100) @(negedge clk_in);
    chk("t6_one_step", {busy, anim_row}, {1'b1, 3'd1});
    slow_force = 1'b0;
    repeat (5) @(negedge clk_in);
    slow_force = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("t6_second_step", anim_row, 2);
    slow_auto = 1'b1;
    wait_done(600, got, lr, mask);
    chk("t6_land", lr, 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && $urandom_range(0, 15) == 0) begin
        for (int c = 0; c < 8; c++) begin
          k_fill = $urandom_range(0, 6);
          board[c] = 6'(((1 << k_fill) - 1) << (6 - k_fill));
          if ($urandom_range(0, 3) == 0) board[c] = 6'($urandom);
        end
      end
      if ($urandom_range(0, 63) == 0) slow_per = $urandom_range(0, 6);
      start  = ($urandom_range(0, 5) == 0);
      col    = 3'($urandom_range(0, 7));
      player = 1'($urandom);
      @(negedge clk_in);
    end
    start = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
